uart_tx_scheduler: RTL

// - Shares one UART byte transmitter (9600 baud, 8N1, fed from clk_12mhz) among NUM_REQ byte sources.
// - Round-robin arbitration; one byte per grant.
// - Per-requester valid/ready capture; issues a 1-cycle tx_start with tx_data and tracks tx_busy.
// - Enforces an idle gap between frames; flags transmitters that never accept a start.

---
 rtl/uart_tx_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one 8N1 UART byte transmitter among NUM_REQ byte sources,
// with start-handshake timeout detection and a forced idle gap between frames.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned GAP_CYCLES  = 1250,
    parameter int unsigned ACK_TIMEOUT = 2600
) (
    input  logic                       clk_12mhz,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       err_timeout
);

    localparam int unsigned ID_W    = $clog2(NUM_REQ);
    localparam int unsigned SUM_W   = ID_W + 1;
    localparam int unsigned CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic        GAP_EN  = (GAP_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      rr_q, rr_d;
    logic [NUM_REQ-1:0]   ready_d;
    logic                 start_d;
    logic [7:0]           data_d;
    logic [ID_W-1:0]      gid_d;
    logic                 active_d;
    logic                 err_d;

    logic                 win_found;
    logic [ID_W-1:0]      win_idx;
    logic [SUM_W-1:0]     cand;

    // First valid requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = SUM_W'(rr_q) + SUM_W'(k);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (!win_found && req_valid[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        ready_d = '0;
        start_d = 1'b0;
        data_d  = tx_data;
        gid_d   = grant_id;
        err_d   = err_timeout;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    data_d           = req_data[{win_idx, 3'b000} +: 8];
                    gid_d            = win_idx;
                    ready_d[win_idx] = 1'b1;
                    start_d          = 1'b1;
                    rr_d             = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    cnt_d            = '0;
                    state_d          = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    // Byte is dropped; the transmitter never acknowledged it.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP_EN ? GAP : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_d   = '0;
                    state_d = GAP_EN ? GAP : IDLE;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_12mhz or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_q        <= '0;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            grant_id    <= '0;
            active      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            req_ready   <= ready_d;
            tx_start    <= start_d;
            tx_data     <= data_d;
            grant_id    <= gid_d;
            active      <= active_d;
            err_timeout <= err_d;
        end
    end

endmodule
